// File: rtl/countdown_timer_if.sv
// countdown_timer_if: control inputs and BCD/status outputs of the countdown timer
interface countdown_timer_if;
  logic       tick;
  logic       load;
  logic [3:0] set_h1;
  logic [3:0] set_h0;
  logic [3:0] set_m1;
  logic [3:0] set_m0;
  logic       start;
  logic       pause;
  logic [3:0] h1;
  logic [3:0] h0;
  logic [3:0] m1;
  logic [3:0] m0;
  logic       running;
  logic       done;
  logic       alarm;
  logic       err;
  modport master (
    output tick, load, set_h1, set_h0, set_m1, set_m0, start, pause,
    input  h1, h0, m1, m0, running, done, alarm, err
  );
  modport slave (
    input  tick, load, set_h1, set_h0, set_m1, set_m0, start, pause,
    output h1, h0, m1, m0, running, done, alarm, err
  );
endinterface

// File: rtl/countdown_timer.sv
// countdown_timer: HH:MM BCD countdown with load/start/pause control and alarm at 00:00
module countdown_timer (
  input  logic               clk_out,
  input  logic               rst,
  countdown_timer_if.slave   bus
);
  typedef enum logic [1:0] {IDLE, RUN, PAUSE, DONE} state_t;
  state_t     state;
  logic [3:0] h1, h0, m1, m0;
  logic [3:0] nh1, nh0, nm1, nm0;
  logic       b1, b2, valid, zero, dec_zero;
  logic       running, done, alarm, err;
  assign valid = !(bus.set_h1 > 4'd2 || (bus.set_h1 == 4'd2 && bus.set_h0 > 4'd3) ||
                   bus.set_h0 > 4'd9 || bus.set_m1 > 4'd5 || bus.set_m0 > 4'd9);
  assign zero = {h1, h0, m1, m0} == 16'd0;
  // borrow ripples m0 -> m1 -> h0 -> h1
  always_comb begin
    b1 = m0 == 4'd0;
    b2 = b1 && m1 == 4'd0;
    nm0 = b1 ? 4'd9 : m0 - 4'd1;
    nm1 = b1 ? (m1 == 4'd0 ? 4'd5 : m1 - 4'd1) : m1;
    nh0 = b2 ? (h0 == 4'd0 ? 4'd9 : h0 - 4'd1) : h0;
    nh1 = (b2 && h0 == 4'd0) ? h1 - 4'd1 : h1;
    dec_zero = {nh1, nh0, nm1, nm0} == 16'd0;
  end
  always_ff @(posedge clk_out or posedge rst) begin
    if (rst) begin
      state <= IDLE;
      {h1, h0, m1, m0} <= 16'd0;
      running <= 1'b0;
      done <= 1'b0;
      alarm <= 1'b0;
      err <= 1'b0;
    end else begin
      done <= 1'b0;
      err <= 1'b0;
      case (state)
        IDLE: begin
          if (bus.load) begin
            if (valid) {h1, h0, m1, m0} <= {bus.set_h1, bus.set_h0, bus.set_m1, bus.set_m0};
            else err <= 1'b1;
          end else if (bus.start && !zero) begin
            state <= RUN;
            running <= 1'b1;
          end
        end
        RUN: begin
          if (bus.tick) {h1, h0, m1, m0} <= {nh1, nh0, nm1, nm0};
          if (bus.tick && dec_zero) begin
            state <= DONE;
            running <= 1'b0;
            done <= 1'b1;
            alarm <= 1'b1;
          end else if (bus.pause) begin
            state <= PAUSE;
            running <= 1'b0;
          end
        end
        PAUSE: begin
          if (bus.load) begin
            if (valid) begin
              {h1, h0, m1, m0} <= {bus.set_h1, bus.set_h0, bus.set_m1, bus.set_m0};
              state <= IDLE;
            end else err <= 1'b1;
          end else if (bus.start) begin
            state <= RUN;
            running <= 1'b1;
          end
        end
        default: begin
          if (bus.load) begin
            if (valid) begin
              {h1, h0, m1, m0} <= {bus.set_h1, bus.set_h0, bus.set_m1, bus.set_m0};
              state <= IDLE;
              alarm <= 1'b0;
            end else err <= 1'b1;
          end else if (bus.start) begin
            state <= IDLE;
            alarm <= 1'b0;
          end
        end
      endcase
    end
  end
  assign bus.h1 = h1;
  assign bus.h0 = h0;
  assign bus.m1 = m1;
  assign bus.m0 = m0;
  assign bus.running = running;
  assign bus.done = done;
  assign bus.alarm = alarm;
  assign bus.err = err;
endmodule

// File: tb/tb_countdown_timer.sv
// tb_countdown_timer: directed checks of load/start/pause/tick, borrow chain, errors and async reset
module tb_countdown_timer;
  logic clk_out;
  logic rst;
  int   checks;
  int   errors;
  countdown_timer_if bus ();
  countdown_timer dut (.clk_out(clk_out), .rst(rst), .bus(bus));
  initial clk_out = 1'b0;
  always #5 clk_out = ~clk_out;
  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %h expected %h", tag, obs, exp);
    end
  endtask
  task automatic chk_all(input string tag, input logic [15:0] cnt, input logic [3:0] st);
    chk({tag, "_cnt"}, {bus.h1, bus.h0, bus.m1, bus.m0}, cnt);
    chk({tag, "_st"}, {12'd0, bus.running, bus.done, bus.alarm, bus.err}, {12'd0, st});
  endtask
  task automatic drive(input logic t, input logic l, input logic s, input logic p, input logic [15:0] v);
    bus.tick = t;
    bus.load = l;
    bus.start = s;
    bus.pause = p;
    {bus.set_h1, bus.set_h0, bus.set_m1, bus.set_m0} = v;
    @(posedge clk_out);
    #1;
    bus.tick = 1'b0;
    bus.load = 1'b0;
    bus.start = 1'b0;
    bus.pause = 1'b0;
  endtask
  initial begin
    checks = 0;
    errors = 0;
    rst = 1'b1;
    drive(0, 0, 0, 0, 16'h0000);
    rst = 1'b0;
    drive(0, 0, 0, 0, 16'h0000);
    chk_all("reset", 16'h0000, 4'b0000);
    drive(0, 1, 0, 0, 16'h0530);
    chk_all("load0530", 16'h0530, 4'b0000);
    drive(0, 0, 1, 0, 16'h0000);
    chk_all("run0530", 16'h0530, 4'b1000);
    #2 rst = 1'b1;
    #1 chk_all("async_rst", 16'h0000, 4'b0000);
    #1 rst = 1'b0;
    drive(0, 0, 0, 0, 16'h0000);
    chk_all("post_rst_idle", 16'h0000, 4'b0000);
    drive(0, 1, 0, 0, 16'h0003);
    drive(0, 0, 1, 0, 16'h0000);
    drive(1, 0, 0, 0, 16'h0000);
    chk_all("tick1", 16'h0002, 4'b1000);
    drive(1, 0, 0, 0, 16'h0000);
    chk_all("tick2", 16'h0001, 4'b1000);
    drive(1, 0, 0, 0, 16'h0000);
    chk_all("tick3_done", 16'h0000, 4'b0110);
    drive(0, 0, 0, 0, 16'h0000);
    chk_all("done_drop", 16'h0000, 4'b0010);
    drive(1, 0, 0, 1, 16'h0000);
    chk_all("done_tick", 16'h0000, 4'b0010);
    drive(0, 1, 0, 0, 16'h1234);
    chk_all("done_load", 16'h1234, 4'b0000);
    drive(0, 1, 0, 0, 16'h0000);
    drive(0, 0, 1, 0, 16'h0000);
    chk_all("zero_start", 16'h0000, 4'b0000);
    drive(0, 1, 0, 0, 16'h2000);
    drive(0, 0, 1, 0, 16'h0000);
    drive(1, 0, 0, 0, 16'h0000);
    chk_all("borrow2000", 16'h1959, 4'b1000);
    drive(0, 1, 0, 0, 16'h0800);
    chk_all("run_load_ign", 16'h1959, 4'b1000);
    drive(0, 0, 0, 1, 16'h0000);
    chk_all("pause", 16'h1959, 4'b0000);
    drive(0, 1, 0, 0, 16'h1000);
    drive(0, 0, 1, 0, 16'h0000);
    drive(1, 0, 0, 0, 16'h0000);
    chk_all("borrow1000", 16'h0959, 4'b1000);
    drive(0, 0, 0, 1, 16'h0000);
    drive(0, 1, 0, 0, 16'h0100);
    drive(0, 0, 1, 0, 16'h0000);
    drive(1, 0, 0, 0, 16'h0000);
    chk_all("borrow0100", 16'h0059, 4'b1000);
    drive(1, 0, 0, 0, 16'h0000);
    chk_all("b2b_tick", 16'h0058, 4'b1000);
    drive(0, 0, 0, 1, 16'h0000);
    drive(0, 1, 0, 0, 16'h2400);
    chk_all("inv2400", 16'h0058, 4'b0001);
    drive(0, 0, 0, 0, 16'h0000);
    chk_all("err_drop", 16'h0058, 4'b0000);
    drive(0, 1, 0, 0, 16'h0960);
    chk_all("inv0960", 16'h0058, 4'b0001);
    drive(0, 1, 1, 0, 16'h1A00);
    chk_all("inv1A00", 16'h0058, 4'b0001);
    drive(0, 0, 1, 0, 16'h0000);
    chk_all("resume", 16'h0058, 4'b1000);
    drive(0, 0, 0, 1, 16'h0000);
    drive(0, 1, 1, 0, 16'h0005);
    chk_all("load_wins", 16'h0005, 4'b0000);
    drive(0, 1, 0, 0, 16'h3000);
    chk_all("idle_inv", 16'h0005, 4'b0001);
    drive(0, 0, 1, 0, 16'h0000);
    drive(1, 0, 0, 1, 16'h0000);
    chk_all("tick_pause", 16'h0004, 4'b0000);
    drive(1, 0, 0, 0, 16'h0000);
    chk_all("paused_tick", 16'h0004, 4'b0000);
    drive(0, 0, 1, 0, 16'h0000);
    drive(1, 0, 0, 0, 16'h0000);
    chk_all("resume_tick", 16'h0003, 4'b1000);
    drive(0, 0, 0, 1, 16'h0000);
    drive(0, 1, 0, 0, 16'h0001);
    drive(0, 0, 1, 0, 16'h0000);
    drive(1, 0, 0, 1, 16'h0000);
    chk_all("zero_over_pause", 16'h0000, 4'b0110);
    drive(0, 0, 1, 0, 16'h0000);
    chk_all("done_start", 16'h0000, 4'b0000);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
